stream_demux4: RTL

- Buffered 1-to-4 demultiplexer. It is the distributing counterpart to the pipeline's N-to-1 select muxes.
- Routes one 32-bit producer stream to one of four consumer lanes, chosen by a 2-bit select.
- Uses valid/ready handshakes on both sides, with an independent FIFO per lane.
- Sits between the pipelined core's result/writeback source and multiple downstream consumers, so that a stalled consumer does not block other lanes until its own FIFO fills.

---
 rtl/stream_demux4.sv | 96 +++++++++
 1 files changed

// File: rtl/stream_demux4.sv
// stream_demux4: buffered 1-to-4 stream demultiplexer.
// One producer stream is routed to four lanes, each with its own FIFO.
module stream_demux4 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Flush,
  input  logic [1:0]       Src,
  input  logic [WIDTH-1:0] InData,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] OutData0,
  output logic [WIDTH-1:0] OutData1,
  output logic [WIDTH-1:0] OutData2,
  output logic [WIDTH-1:0] OutData3,
  output logic [3:0]       OutValid,
  input  logic [3:0]       OutReady,
  output logic [$clog2(DEPTH):0] Count0,
  output logic [$clog2(DEPTH):0] Count1,
  output logic [$clog2(DEPTH):0] Count2,
  output logic [$clog2(DEPTH):0] Count3,
  output logic             Busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q  [4][DEPTH];
  logic [AW-1:0]    wptr_q [4];
  logic [AW-1:0]    rptr_q [4];
  logic [CW-1:0]    cnt_q  [4];

  logic [3:0] push_d;
  logic [3:0] pop_d;
  logic [WIDTH-1:0] head [4];

  // A full lane refuses input even if it is being drained this cycle.
  assign InReady = !Flush && (cnt_q[Src] != FULL);

  // Per-lane push/pop strobes and head data (zero when empty).
  always_comb begin
    push_d = '0;
    pop_d  = '0;
    for (int i = 0; i < 4; i++) begin
      OutValid[i] = (cnt_q[i] != '0);
      push_d[i]   = InValid && InReady && (Src == 2'(i));
      pop_d[i]    = OutValid[i] && OutReady[i];
      head[i]     = OutValid[i] ? mem_q[i][rptr_q[i]] : '0;
    end
  end

  assign OutData0 = head[0];
  assign OutData1 = head[1];
  assign OutData2 = head[2];
  assign OutData3 = head[3];
  assign Count0   = cnt_q[0];
  assign Count1   = cnt_q[1];
  assign Count2   = cnt_q[2];
  assign Count3   = cnt_q[3];
  assign Busy     = |OutValid;

  // All lane storage, pointers and occupancy; flush beats push and pop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
        for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
      end
    end else if (Flush) begin
      for (int i = 0; i < 4; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push_d[i]) begin
          mem_q[i][wptr_q[i]] <= InData;
          wptr_q[i] <= wptr_q[i] + 1'b1;
        end
        if (pop_d[i]) rptr_q[i] <= rptr_q[i] + 1'b1;
        unique case ({push_d[i], pop_d[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + 1'b1;
          2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

endmodule
